// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: pattern/response handshakes and scan pins of scan_chain_ctrl.
// SCAN_CHAIN_CTRL_MISR_EN adds the SIG/SIG_CLR signature signals.
interface scan_chain_ctrl_if #(parameter int CHAIN_LEN = 16);
    logic PAT_VALID, PAT_READY, SE, SI, SO, RES_VALID, RES_READY, BUSY;
    logic [CHAIN_LEN-1:0] PAT_DATA, RES_DATA;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    logic [15:0] SIG;
    logic SIG_CLR;
    modport slave (input PAT_VALID, PAT_DATA, SO, RES_READY, SIG_CLR,
                   output PAT_READY, SE, SI, RES_VALID, RES_DATA, BUSY, SIG);
    modport master (output PAT_VALID, PAT_DATA, SO, RES_READY, SIG_CLR,
                    input PAT_READY, SE, SI, RES_VALID, RES_DATA, BUSY, SIG);
`else
    modport slave (input PAT_VALID, PAT_DATA, SO, RES_READY,
                   output PAT_READY, SE, SI, RES_VALID, RES_DATA, BUSY);
    modport master (output PAT_VALID, PAT_DATA, SO, RES_READY,
                    input PAT_READY, SE, SI, RES_VALID, RES_DATA, BUSY);
`endif
endinterface

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences load, capture and unload of a scan chain with ready/valid pattern and response.
// SCAN_CHAIN_CTRL_MISR_EN adds a 16-bit signature (x^16+x^12+x^5+1) over every unloaded SO bit.
module scan_chain_ctrl #(parameter int CHAIN_LEN = 16) (
    input logic CLK,
    input logic RST,
    scan_chain_ctrl_if.slave bus
);
    localparam int CW = $clog2(CHAIN_LEN);
    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CHAIN_LEN-1:0] pat, pat_n, res;
    logic se, si, se_n, si_n, last;
    assign last = cnt == CW'(CHAIN_LEN - 1);
    always_comb begin
        state_n = state;
        pat_n = pat;
        case (state)
            IDLE: if (bus.PAT_VALID) begin
                state_n = LOAD;
                pat_n = bus.PAT_DATA;
            end
            LOAD: if (last) state_n = CAPTURE;
            CAPTURE: state_n = UNLOAD;
            UNLOAD: if (last) state_n = DONE;
            DONE: if (bus.RES_READY) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cnt_n = state_n != state ? '0 : (state == LOAD || state == UNLOAD) ? cnt + 1'b1 : cnt;
        // SE/SI are registered, so they are computed from the state being entered
        se_n = state_n == LOAD || state_n == UNLOAD;
        si_n = state_n == LOAD && pat_n[cnt_n];
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            pat <= '0;
            res <= '0;
            se <= 1'b0;
            si <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            pat <= pat_n;
            se <= se_n;
            si <= si_n;
            if (state == UNLOAD) res[cnt] <= bus.SO;
        end
    assign bus.PAT_READY = state == IDLE;
    assign bus.BUSY = state != IDLE;
    assign bus.RES_VALID = state == DONE;
    assign bus.RES_DATA = res;
    assign bus.SE = se;
    assign bus.SI = si;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    logic [15:0] sig;
    always_ff @(posedge CLK or posedge RST)
        if (RST) sig <= '0;
        else if (bus.SIG_CLR) sig <= '0;
        else if (state == UNLOAD) sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ bus.SO) ? 16'h1021 : 16'h0000);
    assign bus.SIG = sig;
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: scoreboard bench for scan_chain_ctrl with an inverting-capture chain model.
// Covers CHAIN_LEN 16 and 2; signature checks when SCAN_CHAIN_CTRL_MISR_EN is defined.
module tb_scan_chain_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    int n_cmp = 0, n_bad = 0;
    logic [15:0] sb[$];
    logic [1:0] sb1[$];
    logic [15:0] ch0;
    logic [1:0] ch1;
    always #5 clk = ~clk;
    scan_chain_ctrl_if #(.CHAIN_LEN(16)) b0();
    scan_chain_ctrl_if #(.CHAIN_LEN(2)) b1();
    scan_chain_ctrl #(.CHAIN_LEN(16)) u0 (.CLK(clk), .RST(rst), .bus(b0));
    scan_chain_ctrl #(.CHAIN_LEN(2)) u1 (.CLK(clk), .RST(rst), .bus(b1));
    // chain captures its own inverted contents when SE=0
    always @(posedge clk) ch0 <= b0.SE ? {ch0[14:0], b0.SI} : ~ch0;
    always @(posedge clk) ch1 <= b1.SE ? {ch1[0], b1.SI} : ~ch1;
    assign b0.SO = ch0[15];
    assign b1.SO = ch1[1];
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run(input logic [15:0] p, input int bp, input bit keep);
        int n;
        logic [15:0] e;
        e = ~p;
        b0.PAT_DATA = p;
        b0.PAT_VALID = 1'b1;
        chk("pat_ready_idle", b0.PAT_READY, 1);
        sb.push_back(e);
        tick;
        if (keep) b0.PAT_DATA = ~p;
        else b0.PAT_VALID = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("load_se", b0.SE, 1);
            chk("load_si", b0.SI, p[k]);
            chk("load_ready", b0.PAT_READY, 0);
            b0.RES_READY = keep && k == 5;
            tick;
        end
        b0.RES_READY = 1'b0;
        chk("cap_se", b0.SE, 0);
        chk("cap_si", b0.SI, 0);
        n = 16;
        while (!b0.RES_VALID && n < 60) begin
            tick;
            n++;
        end
        chk("latency", n, 33);
        chk("res_data", b0.RES_DATA, sb.pop_front());
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", b0.RES_VALID, 1);
            chk("bp_data", b0.RES_DATA, e);
            chk("bp_se", b0.SE, 0);
            chk("bp_ready", b0.PAT_READY, 0);
            tick;
        end
        b0.RES_READY = 1'b1;
        tick;
        b0.RES_READY = 1'b0;
        chk("idle_valid", b0.RES_VALID, 0);
        chk("idle_busy", b0.BUSY, 0);
        chk("idle_ready", b0.PAT_READY, 1);
    endtask
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    function automatic logic [15:0] step(input logic [15:0] m, input logic b);
        return {m[14:0], 1'b0} ^ ((m[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
`endif
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n, seen;
        b0.PAT_VALID = 0; b0.PAT_DATA = '0; b0.RES_READY = 0;
        b1.PAT_VALID = 0; b1.PAT_DATA = '0; b1.RES_READY = 0;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
        b0.SIG_CLR = 0; b1.SIG_CLR = 0;
`endif
        repeat (2) tick;
        chk("rst_se", b0.SE, 0);
        chk("rst_si", b0.SI, 0);
        chk("rst_valid", b0.RES_VALID, 0);
        chk("rst_data", b0.RES_DATA, 0);
        chk("rst_busy", b0.BUSY, 0);
        chk("rst_ready", b0.PAT_READY, 1);
`ifdef SCAN_CHAIN_CTRL_MISR_EN
        chk("rst_sig", b0.SIG, 0);
`endif
        rst = 1'b0;
        tick;
        chk("post_rst_ready", b0.PAT_READY, 1);
        run(16'hA5C3, 10, 1'b0);
        run(16'h0000, 0, 1'b0);
        run(16'($urandom), 3, 1'b0);
        run(16'($urandom), 0, 1'b1);
        run(16'h3C96, 0, 1'b1);
        b0.PAT_VALID = 1'b0;
        tick;
        chk("no_extra_accept", b0.BUSY, 0);
        b0.PAT_DATA = 16'h1234;
        b0.PAT_VALID = 1'b1;
        tick;
        b0.PAT_VALID = 1'b0;
        repeat (24) tick;
        chk("pre_rst_busy", b0.BUSY, 1);
        chk("pre_rst_se", b0.SE, 1);
        rst = 1'b1;
        #1;
        chk("abort_se", b0.SE, 0);
        chk("abort_si", b0.SI, 0);
        chk("abort_busy", b0.BUSY, 0);
        chk("abort_valid", b0.RES_VALID, 0);
        tick;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick;
            seen |= int'(b0.RES_VALID);
        end
        chk("abort_no_valid", seen, 0);
        run(16'hFFFF, 2, 1'b0);
        b1.PAT_DATA = 2'b10;
        b1.PAT_VALID = 1'b1;
        sb1.push_back(2'b01);
        tick;
        b1.PAT_VALID = 1'b0;
        chk("l2_se0", b1.SE, 1);
        chk("l2_si0", b1.SI, 0);
        tick;
        chk("l2_si1", b1.SI, 1);
        tick;
        chk("l2_cap_se", b1.SE, 0);
        n = 2;
        while (!b1.RES_VALID && n < 20) begin
            tick;
            n++;
        end
        chk("l2_latency", n, 5);
        chk("l2_res", b1.RES_DATA, sb1.pop_front());
        b1.RES_READY = 1'b1;
        tick;
        b1.RES_READY = 1'b0;
        chk("l2_idle", b1.PAT_READY, 1);
`ifdef SCAN_CHAIN_CTRL_MISR_EN
        begin
            logic [15:0] model;
            b0.SIG_CLR = 1'b1;
            tick;
            b0.SIG_CLR = 1'b0;
            chk("sig_clr0", b0.SIG, 0);
            model = '0;
            repeat (2) begin
                run(16'hFFFE, 0, 1'b0);
                for (int k = 0; k < 16; k++) model = step(model, k == 0);
            end
            chk("sig_model", b0.SIG, model);
            b0.SIG_CLR = 1'b1;
            tick;
            b0.SIG_CLR = 1'b0;
            chk("sig_clr", b0.SIG, 0);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
